// File: rtl/stream_label_finder.sv
// stream_label_finder: streaming argmax over a multi-beat score vector, lowest index wins ties
module stream_label_finder #(
    parameter int N             = 8,
    parameter int NUM_LABELS    = 10,
    parameter int LANES         = 2,
    parameter int CLOG2_LABELS  = 4,
    parameter int SIGNED_SCORES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*N-1:0]      in_scores,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CLOG2_LABELS-1:0] out_label,
    output logic [N-1:0]            out_max,
    output logic                    out_tie
);
    localparam int BEATS = NUM_LABELS / LANES;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_nxt;
    logic [BW-1:0]           beat_cnt;
    logic [N-1:0]            run_max, f_max, s;
    logic [CLOG2_LABELS-1:0] run_label, f_label, lab;
    logic                    run_tie, f_tie, accept, last;

    function automatic logic gt(input logic [N-1:0] a, input logic [N-1:0] b);
        return SIGNED_SCORES != 0 ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    assign accept = in_valid && in_ready && !clear;
    assign last   = beat_cnt == BW'(BEATS - 1);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: clear beats everything, then result handshake, then beat acceptance
    always_comb begin
        state_nxt = state;
        if (clear)                          state_nxt = IDLE;
        else if (state == DONE)             state_nxt = out_ready ? IDLE : DONE;
        else if (accept && last)            state_nxt = DONE;
        else if (accept && state == IDLE)   state_nxt = ACCUM;
    end

    // handshake outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = rst_n && state != DONE;
        out_valid = state == DONE;
    end

    // fold this beat's lanes into the running max, lowest lane first, strictly-greater replaces
    always_comb begin
        f_max   = run_max;
        f_label = run_label;
        f_tie   = run_tie;
        s       = '0;
        lab     = '0;
        for (int k = 0; k < LANES; k++) begin
            s   = in_scores[N*k +: N];
            lab = CLOG2_LABELS'(int'(beat_cnt) * LANES + k);
            if ((state == IDLE && k == 0) || gt(s, f_max)) begin
                f_max   = s;
                f_label = lab;
                f_tie   = 1'b0;
            end else if (s == f_max) begin
                f_tie = 1'b1;
            end
        end
    end

    // running max and beat count update per accepted beat; outputs load only on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            run_max   <= '0;
            run_label <= '0;
            run_tie   <= 1'b0;
            out_label <= '0;
            out_max   <= '0;
            out_tie   <= 1'b0;
        end else if (clear) begin
            beat_cnt  <= '0;
            out_label <= '0;
            out_max   <= '0;
            out_tie   <= 1'b0;
        end else if (accept) begin
            beat_cnt  <= last ? '0 : beat_cnt + 1'b1;
            run_max   <= f_max;
            run_label <= f_label;
            run_tie   <= f_tie;
            if (last) begin
                out_label <= f_label;
                out_max   <= f_max;
                out_tie   <= f_tie;
            end
        end
    end
endmodule
